pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: the FSM state
//   encoding and the default data-memory wait limit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    // Maximum data-memory wait cycles before a timeout (legal range 1..15).
    localparam int unsigned WAIT_MAX_DEFAULT = 15;

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for a classic 5-stage pipeline. It handles three cases:
//   data-memory stalls with a timeout, taken-branch flushes resolved in MEM,
//   and load-use stalls detected in ID. The priority is
//   memory stall > taken branch > load-use.
//
// Ports
//   clk, reset            : clock; synchronous active-low reset
//   ID_rs, ID_rt          : source registers of the instruction in ID
//   Ex_rd, Ex_MemRead     : destination register and load flag of the EX instruction
//   MEM_MemRead/MemWrite  : MEM-stage data access
//   MEM_Branch, MEM_zero  : MEM-stage branch and its registered zero flag
//   mem_ack               : data memory completes the access this cycle
//   PC_write, PC_sel      : PC enable; select the branch target
//   IF_ID_write/flush     : IF/ID load enable; load a bubble
//   ID_EX_flush           : zero the ID/EX control fields
//   EX_MEM_hold/flush     : hold EX/MEM; zero the EX/MEM control fields
//   mem_req               : data-memory request
//   mem_err               : sticky timeout flag
//   stall_cnt             : saturating count of cycles with PC_write=0
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [4:0]  Ex_rd,
    input  logic        Ex_MemRead,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_Branch,
    input  logic        MEM_zero,
    input  logic        mem_ack,
    output logic        PC_write,
    output logic        PC_sel,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_hold,
    output logic        EX_MEM_flush,
    output logic        mem_req,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] WAIT_MAX_L = 4'(WAIT_MAX);

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        req_raw;
    logic        stall;
    logic        taken;
    logic        load_use;

    assign req_raw = MEM_MemRead | MEM_MemWrite;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;
        stall        = 1'b0;
        taken        = 1'b0;
        load_use     = 1'b0;
        PC_write     = 1'b1;
        PC_sel       = 1'b0;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_hold  = 1'b0;
        EX_MEM_flush = 1'b0;
        mem_req      = 1'b0;

        case (state_q)
            RUN: begin
                mem_req = req_raw;
                if (req_raw && !mem_ack) begin
                    stall      = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 4'd1;
                end
            end
            MEM_WAIT: begin
                mem_req = req_raw;
                if (!mem_ack) begin
                    if (wait_cnt_q == WAIT_MAX_L) begin
                        // Timeout: give up on the access and let the pipe move.
                        mem_err_d  = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = RUN;
                    end else begin
                        stall      = 1'b1;
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        // A branch can only resolve once the memory stall has been released;
        // in FLUSH the MEM stage holds a bubble, so nothing is evaluated there.
        taken = (state_q != FLUSH) && !stall && MEM_Branch && MEM_zero;

        load_use = (state_q == RUN) && !stall && !taken && Ex_MemRead &&
                   (Ex_rd != 5'd0) && ((Ex_rd == ID_rs) || (Ex_rd == ID_rt));

        if (stall) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            EX_MEM_hold = 1'b1;
        end else if (taken) begin
            PC_sel       = 1'b1;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            state_d      = FLUSH;
        end else if (load_use) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end

        if (!reset) begin
            PC_write     = 1'b0;
            PC_sel       = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_hold  = 1'b0;
            EX_MEM_flush = 1'b1;
            mem_req      = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!PC_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed vector table with hand-derived expectations, followed by
//   randomized stimulus checked against a behavioural model of the
//   hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned WMAX = 15;

    // Control vector bit order:
    // {PC_write, PC_sel, IF_ID_write, IF_ID_flush, ID_EX_flush,
    //  EX_MEM_hold, EX_MEM_flush, mem_req, mem_err}
    localparam logic [8:0] C_RST = 9'b000110100;
    localparam logic [8:0] C_NRM = 9'b101000000;
    localparam logic [8:0] C_LU  = 9'b000010000;
    localparam logic [8:0] C_STL = 9'b000001010;
    localparam logic [8:0] C_REL = 9'b101000010;
    localparam logic [8:0] C_BR  = 9'b111110100;
    localparam logic [8:0] C_BRQ = 9'b111110110;

    typedef struct {
        logic        rst_n;
        logic [4:0]  rs, rt, rd;
        logic        exmr, mr, mw, br, z, ack;
        logic [8:0]  ctl;
        logic [31:0] sc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, Ex_rd;
    logic        Ex_MemRead, MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_zero, mem_ack;
    logic        PC_write, PC_sel, IF_ID_write, IF_ID_flush, ID_EX_flush;
    logic        EX_MEM_hold, EX_MEM_flush, mem_req, mem_err;
    logic [31:0] stall_cnt;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Behavioural model state
    bit          m_waiting = 0;
    bit          m_flushing = 0;
    int unsigned m_waited = 0;
    bit          m_err = 0;
    longint unsigned m_stalls = 0;

    vec_t tbl[$];

    pipe_hazard_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .ID_rs       (ID_rs),
        .ID_rt       (ID_rt),
        .Ex_rd       (Ex_rd),
        .Ex_MemRead  (Ex_MemRead),
        .MEM_MemRead (MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite),
        .MEM_Branch  (MEM_Branch),
        .MEM_zero    (MEM_zero),
        .mem_ack     (mem_ack),
        .PC_write    (PC_write),
        .PC_sel      (PC_sel),
        .IF_ID_write (IF_ID_write),
        .IF_ID_flush (IF_ID_flush),
        .ID_EX_flush (ID_EX_flush),
        .EX_MEM_hold (EX_MEM_hold),
        .EX_MEM_flush(EX_MEM_flush),
        .mem_req     (mem_req),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst_n, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic exmr, logic mr, logic mw, logic br, logic z, logic ack,
                                logic [8:0] ctl, logic [31:0] sc);
        vec_t v;
        v.rst_n = rst_n; v.rs = rs; v.rt = rt; v.rd = rd;
        v.exmr = exmr; v.mr = mr; v.mw = mw; v.br = br; v.z = z; v.ack = ack;
        v.ctl = ctl; v.sc = sc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected behaviour for the current cycle, then advance the model.
    task automatic model_step(input vec_t v, output logic [8:0] ctl, output logic [31:0] sc);
        bit req, stl, tmo, tk, lu, pcw;
        sc = m_stalls[31:0];
        if (!v.rst_n) begin
            ctl = {8'b00011010, m_err};
            m_waiting = 0; m_flushing = 0; m_waited = 0; m_err = 0; m_stalls = 0;
            return;
        end
        req = !m_flushing && (v.mr || v.mw);
        if (m_waiting) begin
            stl = !v.ack && (m_waited < WMAX);
            tmo = !v.ack && (m_waited == WMAX);
        end else begin
            stl = req && !v.ack;
            tmo = 0;
        end
        tk  = !m_flushing && !stl && v.br && v.z;
        lu  = !m_waiting && !m_flushing && !stl && !tk && v.exmr && (v.rd != 0) &&
              ((v.rd == v.rs) || (v.rd == v.rt));
        pcw = !(stl || lu);
        ctl = {pcw, tk, pcw, tk, tk || lu, stl, tk, req, m_err};
        if (!pcw && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        m_waited   = stl ? m_waited + 1 : 0;
        m_waiting  = stl;
        m_flushing = tk;
        if (tmo) m_err = 1;
    endtask

    task automatic apply(input vec_t v, input bit use_tbl, input int idx);
        logic [8:0]  ectl;
        logic [31:0] esc;
        logic [8:0]  actl;
        @(negedge clk);
        reset = v.rst_n; ID_rs = v.rs; ID_rt = v.rt; Ex_rd = v.rd;
        Ex_MemRead = v.exmr; MEM_MemRead = v.mr; MEM_MemWrite = v.mw;
        MEM_Branch = v.br; MEM_zero = v.z; mem_ack = v.ack;
        #1;
        actl = {PC_write, PC_sel, IF_ID_write, IF_ID_flush, ID_EX_flush,
                EX_MEM_hold, EX_MEM_flush, mem_req, mem_err};
        model_step(v, ectl, esc);
        if (use_tbl) begin
            chk($sformatf("vec%0d_ctl", idx), {23'd0, actl}, {23'd0, v.ctl});
            chk($sformatf("vec%0d_stall_cnt", idx), stall_cnt, v.sc);
        end
        chk($sformatf("model%0d_ctl", idx), {23'd0, actl}, {23'd0, ectl});
        chk($sformatf("model%0d_stall_cnt", idx), stall_cnt, esc);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; ID_rs = '0; ID_rt = '0; Ex_rd = '0; Ex_MemRead = 1'b0;
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_Branch = 1'b0; MEM_zero = 1'b0;
        mem_ack = 1'b0;

        //            rst rs rt rd exmr mr mw br z ack  ctl    sc
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, C_RST, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM, 0));
        tbl.push_back(mk(1, 1, 8, 8, 1, 0, 0, 0, 0, 0, C_LU,  0));  // load-use via rt
        tbl.push_back(mk(1, 1, 8, 8, 0, 0, 0, 0, 0, 0, C_NRM, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_NRM, 1));  // rd=0 never hazards
        tbl.push_back(mk(1, 5, 2, 5, 1, 0, 0, 0, 0, 0, C_LU,  1));  // load-use via rs
        tbl.push_back(mk(1, 5, 2, 5, 0, 0, 0, 0, 0, 0, C_NRM, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STL, 2));  // 3 wait cycles
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STL, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STL, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_REL, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_BR,  5));  // taken branch
        tbl.push_back(mk(1, 1, 8, 8, 1, 1, 0, 0, 0, 0, C_NRM, 5));  // FLUSH ignores hazards
        tbl.push_back(mk(1, 1, 8, 8, 1, 0, 0, 0, 0, 0, C_LU,  5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM, 6));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_NRM, 6));  // not taken
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, C_STL, 6));  // stall beats branch
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, C_BRQ, 7));  // ack + branch
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM, 7));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STL, 7));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STL, 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_RST, 9));  // reset mid-wait
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_REL, 0));  // back in RUN
        for (int i = 0; i < int'(WMAX); i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STL, 32'(i)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_REL, WMAX));          // timeout
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM | 9'd1, WMAX));
        tbl.push_back(mk(1, 3, 9, 9, 1, 0, 0, 0, 0, 0, C_LU | 9'd1, WMAX));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST | 9'd1, WMAX + 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM, 0));

        foreach (tbl[i]) apply(tbl[i], 1'b1, i);

        for (int n = 0; n < 3000; n++) begin
            v.rst_n = ($urandom_range(0, 99) != 0);
            v.rs    = 5'($urandom_range(0, 3));
            v.rt    = 5'($urandom_range(0, 3));
            v.rd    = 5'($urandom_range(0, 3));
            v.exmr  = 1'($urandom);
            v.mr    = ($urandom_range(0, 3) == 0);
            v.mw    = ($urandom_range(0, 5) == 0);
            v.br    = 1'($urandom);
            v.z     = 1'($urandom);
            v.ack   = (n >= 1500 && n < 1600) ? 1'b0 : ($urandom_range(0, 2) == 0);
            v.ctl   = '0;
            v.sc    = '0;
            apply(v, 1'b0, 1000 + n);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
